// File: rtl/inst_encode_loader_pkg.sv
// Shared constants, FSM states and request payload for the instruction encode/loader.
package inst_encode_loader_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned OP_W   = 7;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned F7_W   = 7;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned CNT1_W = CNT_W + 1;

   localparam logic [OP_W-1:0] OP_ARITHMETIC     = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ARITHMETIC_IMM = 7'b0010011;
   localparam logic [OP_W-1:0] OP_LOAD           = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE          = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BRANCH         = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL            = 7'b1101111;
   localparam logic [OP_W-1:0] OP_JALR           = 7'b1100111;
   localparam logic [OP_W-1:0] OP_ECALL          = 7'b1110011;

   localparam logic [F3_W-1:0] F3_SLL = 3'b001;
   localparam logic [F3_W-1:0] F3_SRL = 3'b101;

   localparam logic [XLEN-1:0] ECALL_WORD = 32'h0000_0073;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]  opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
      logic [XLEN-1:0]  imm;
   } req_fields_t;

   // Signed range test of a sign-extended immediate.
   function automatic logic in_range(input logic [XLEN-1:0] v, input int lo, input int hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/inst_field_packer.sv
// Combinational field packer: request fields -> RV32I word plus a reject flag.
module inst_field_packer
   import inst_encode_loader_pkg::*;
(
   input  req_fields_t     fields,
   output logic [XLEN-1:0] word,
   output logic            bad
);

   logic [XLEN-1:0]  imm;
   logic [OP_W-1:0]  op;
   logic [F3_W-1:0]  f3;

   assign imm = fields.imm;
   assign op  = fields.opcode;
   assign f3  = fields.funct3;

   // Format select, bit placement and immediate range check per opcode.
   always_comb begin
      word = '0;
      bad  = 1'b0;
      case (op)
         OP_ARITHMETIC: begin
            word = {fields.funct7, fields.rs2, fields.rs1, f3, fields.rd, op};
         end
         OP_ARITHMETIC_IMM: begin
            if (f3 == F3_SLL || f3 == F3_SRL) begin
               word = {fields.funct7, imm[4:0], fields.rs1, f3, fields.rd, op};
               bad  = !in_range(imm, 0, 31);
            end else begin
               word = {imm[11:0], fields.rs1, f3, fields.rd, op};
               bad  = !in_range(imm, -2048, 2047);
            end
         end
         OP_LOAD, OP_JALR: begin
            word = {imm[11:0], fields.rs1, f3, fields.rd, op};
            bad  = !in_range(imm, -2048, 2047);
         end
         OP_STORE: begin
            word = {imm[11:5], fields.rs2, fields.rs1, f3, imm[4:0], op};
            bad  = !in_range(imm, -2048, 2047);
         end
         OP_BRANCH: begin
            word = {imm[12], imm[10:5], fields.rs2, fields.rs1, f3, imm[4:1], imm[11], op};
            bad  = !in_range(imm, -4096, 4094) || imm[0];
         end
         OP_JAL: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, op};
            bad  = !in_range(imm, -1048576, 1048574) || imm[0];
         end
         OP_ECALL: begin
            word = ECALL_WORD;
         end
         default: begin
            bad = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encode_loader.sv
// Encodes request bundles into RV32I words and streams them to instruction memory.
module inst_encode_loader
   import inst_encode_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MEM_WORDS = 1024
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_last,
   input  logic [OP_W-1:0]   req_opcode,
   input  logic [REG_W-1:0]  req_rd,
   input  logic [REG_W-1:0]  req_rs1,
   input  logic [REG_W-1:0]  req_rs2,
   input  logic [F3_W-1:0]   req_funct3,
   input  logic [F7_W-1:0]   req_funct7,
   input  logic [XLEN-1:0]   req_imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  word_count
);

   state_t            state;
   state_t            state_next;
   req_fields_t       fields;
   logic [XLEN-1:0]   enc_word;
   logic              enc_bad;
   logic [CNT1_W-1:0] in_flight;
   logic              full;
   logic              accept;
   logic              retire;
   logic              load_base;
   logic              overflow;

   assign fields.opcode = req_opcode;
   assign fields.rd     = req_rd;
   assign fields.rs1    = req_rs1;
   assign fields.rs2    = req_rs2;
   assign fields.funct3 = req_funct3;
   assign fields.funct7 = req_funct7;
   assign fields.imm    = req_imm;

   inst_field_packer u_packer (
      .fields (fields),
      .word   (enc_word),
      .bad    (enc_bad)
   );

   // Written words plus the buffered one; memory is full when this reaches MEM_WORDS.
   assign in_flight = {1'b0, word_count} + CNT1_W'(mem_we);
   assign full      = (in_flight == CNT1_W'(MEM_WORDS));

   assign req_ready = (state == ST_RUN) && (!mem_we || mem_ready) && !full;
   assign accept    = req_valid && req_ready;
   assign retire    = mem_we && mem_ready;
   assign load_base = (state == ST_IDLE) && start;
   assign overflow  = (state == ST_RUN) && full && req_valid;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start)               state_next = ST_RUN;
         ST_RUN:   if (accept && req_last)  state_next = ST_DRAIN;
         ST_DRAIN: if (!mem_we || retire)   state_next = ST_DONE;
         ST_DONE:                           state_next = ST_IDLE;
         default:                           state_next = ST_IDLE;
      endcase
   end

   // Output buffer, address/count tracking and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
      end else begin
         busy <= (state_next != ST_IDLE);
         done <= (state_next == ST_DONE);

         if (load_base) begin
            mem_addr   <= base_addr & ~ADDR_W'(3);
            word_count <= '0;
            err        <= 1'b0;
         end else begin
            if (retire) begin
               mem_addr <= mem_addr + ADDR_W'(4);
               if (word_count != '1) word_count <= word_count + CNT_W'(1);
            end
            if ((accept && enc_bad) || overflow) err <= 1'b1;
         end

         if (accept && !enc_bad) begin
            mem_we    <= 1'b1;
            mem_wdata <= enc_word;
         end else if (retire) begin
            mem_we <= 1'b0;
         end
      end
   end

endmodule
